gpu_result_streamer: RTL
========================

# gpu_result_streamer

Drains the GPU's flat `result_matrix` bus (256 × 32-bit words, word *i* at bits [i*32 +: 32]) as a serial word stream with a valid/ready handshake. It is the read-side counterpart of the flat-bus matrix loading done for `input_matrix_A`/`input_matrix_B`. It sits between the GPU core and a host/DMA sink. It snapshots the result on a start pulse so the stream cannot be corrupted if the core keeps computing.

## Interface
- `N_WORDS`, 256, number of words in the matrix bus
- `WORD_W`, 32, bits per word
- `IDX_W`, 8, width of the word index (must satisfy 2^IDX_W ≥ N_WORDS)

- `CLK`  in  1  clock, all state on rising edge
- `RES_N`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to snapshot `result_matrix` and stream it
- `abort`  in  1  synchronous cancel of an in-progress stream
- `result_matrix`  in  N_WORDS*WORD_W  flat result bus from the GPU core
- `busy`  out  1  high from the cycle after an accepted start until return to IDLE
- `out_valid`  out  1  `out_data` holds a valid word
- `out_ready`  in  1  sink accepts the word this cycle
- `out_data`  out  WORD_W  current word, signed two's complement, passed through unmodified
- `out_index`  out  IDX_W  index of the current word (0 = bits [WORD_W-1:0])
- `out_last`  out  1  high while `out_index == N_WORDS-1` and `out_valid`
- `done`  out  1  one-cycle pulse after the last word handshake

## Operation
- States: IDLE, STREAM, DONE.
- IDLE
  - `start=1` → capture all of `result_matrix` into an internal snapshot register, clear the index to 0, go to STREAM.
  - `abort` is ignored in IDLE.
- STREAM
  - `out_valid=1`; `out_data` = snapshot word[index].
  - Handshake = `out_valid & out_ready`.
  - On a handshake with index < N_WORDS-1: index increments by 1.
  - On a handshake with index = N_WORDS-1: go to DONE. The index does not wrap visibly.
  - `start` is ignored in STREAM. The snapshot is never re-captured mid-stream.
  - `abort=1` → IDLE next cycle, with no `done` pulse. `abort` wins over a simultaneous handshake.
- DONE
  - `done=1`, `out_valid=0`, `busy=1` for exactly one cycle, then IDLE.
  - `start` in DONE is ignored.
- AXI-stream rule: once `out_valid` rises, it stays high and `out_data`/`out_index`/`out_last` stay stable until the handshake, or until `abort`.
- Changes on `result_matrix` after the capture cycle must not affect `out_data`.

## Timing
- Reset (async assert, sync deassert by the system) values:
  - state IDLE, index 0, snapshot all zeros
  - `busy=0`, `out_valid=0`, `out_data=0`, `out_index=0`, `out_last=0`, `done=0`
- Start latency: `start` sampled high at edge *t* → `out_valid=1` with word 0 after edge *t*. This means word 0 is presented in the cycle following the start cycle.
- Throughput: with `out_ready` held high, one word per cycle. The full stream takes N_WORDS cycles in STREAM.
- Start to `done` with `out_ready` tied high: `done` is high in the cycle after edge *t*+N_WORDS, i.e. N_WORDS+1 cycles after the start cycle.
- Back-to-back operation: a `start` in the cycle after DONE (state IDLE) is accepted. The minimum gap between streams is one idle cycle.
- All outputs are registered or decoded directly from registered state. There is no combinational path from `out_ready` to `out_valid`.
- `RES_N` low mid-stream: outputs drop to their reset values immediately (asynchronously), without waiting for a clock edge.

## Test plan
- Load `result_matrix` word[i]=i*3−100 (signed) and tie `out_ready=1`, then pulse `start`.
  - Expect 256 consecutive words −100, −97, …, 665 with `out_index` 0..255.
  - Expect `out_last` only at index 255 and `done` exactly one cycle after the last handshake.
- Toggle `out_ready` in a pseudo-random pattern.
  - Every word appears exactly once, in order.
  - While `out_valid=1 & out_ready=0`, `out_data`/`out_index` are unchanged.
- Overwrite `result_matrix` with all 0xDEADBEEF in the cycle after `start`.
  - The streamed words still equal the pre-start values.
- Pulse `start` at index 10 mid-stream; pulse `abort` at index 50 together with `out_ready=1`.
  - The extra `start` is ignored.
  - After the abort: `out_valid=0`, `busy=0`, no `done` pulse, and `out_index` returns to 0 on the next `start`.
- Assert `RES_N=0` asynchronously at index 100, between clock edges.
  - `out_valid`, `busy` and `out_index` clear immediately.
  - After release, a new `start` streams from word 0.
- Pulse `start` in the IDLE cycle right after `done`.
  - The second stream begins with word 0 one cycle later.

Source files
------------

// File: rtl/gpu_result_streamer_if.sv
// Result stream channel: valid/ready word stream with index and last marker.
interface gpu_result_streamer_if #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  modport master (output out_valid, out_data, out_index, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/gpu_result_streamer.sv
// Snapshots the flat result_matrix bus on start and streams it out one word
// per handshake. The snapshot isolates the stream from a core that keeps
// computing after the capture cycle.
module gpu_result_streamer #(
  parameter int N_WORDS = 256,
  parameter int WORD_W  = 32,
  parameter int IDX_W   = 8
) (
  input  logic                      CLK,
  input  logic                      RES_N,
  input  logic                      start,
  input  logic                      abort,
  input  logic [N_WORDS*WORD_W-1:0] result_matrix,
  output logic                      busy,
  output logic                      done,
  gpu_result_streamer_if.master     st
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_t                         state, state_nxt;
  logic [IDX_W-1:0]               idx;
  logic [N_WORDS-1:0][WORD_W-1:0] snap;
  logic                           hs;
  logic                           at_last;
  logic                           accept;

  // Valid is purely state-decoded, so out_ready never reaches out_valid.
  assign hs      = (state == STREAM) & st.out_ready;
  assign at_last = (idx == LAST_IDX);
  assign accept  = (state == IDLE) & start;

  // State register.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: abort beats a simultaneous handshake; start only counts in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (abort) state_nxt = IDLE;
               else if (hs && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word index: cleared on capture, advanced per handshake, parked at the
  // last word so it never wraps while valid; cleared again on leaving.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N)                                idx <= '0;
    else if (accept)                           idx <= '0;
    else if (state == STREAM && abort)         idx <= '0;
    else if (state == STREAM && hs && !at_last) idx <= idx + 1'b1;
    else if (state == DONE)                    idx <= '0;
  end

  // Snapshot: word i of the flat bus lands in snap[i] (packed order matches).
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N)      snap <= '0;
    else if (accept) snap <= result_matrix;
  end

  // Outputs decoded from registered state only; data held stable while stalled.
  always_comb begin
    st.out_valid = (state == STREAM);
    st.out_data  = st.out_valid ? snap[idx] : '0;
    st.out_index = idx;
    st.out_last  = st.out_valid & at_last;
    busy         = (state != IDLE);
    done         = (state == DONE);
  end

endmodule
